// File: rtl/mux2_arb.sv
// Two-requester burst arbiter that feeds one registered 8-bit output stage.
// Grants alternate on ties and after a requester reaches the MAXBURST limit.
module mux2_arb #(
  parameter int unsigned MAXBURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] d0,
  input  logic       req1,
  input  logic [7:0] d1,
  input  logic       rdy,
  output logic       gnt0,
  output logic       gnt1,
  output logic       s,
  output logic [7:0] y,
  output logic       vld
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DAT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXBURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               hand_q, hand_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               s_q, s_d;
  logic [DAT_W-1:0]   y_q, y_d;
  logic               vld_q, vld_d;

  logic free_c, acc0_c, acc1_c;

  // State and output registers; reset makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      hand_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      s_q     <= 1'b0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      hand_q  <= hand_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      s_q     <= s_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
    end
  end

  // hand_q blocks the first grant cycle after a burst-limit handover.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    hand_d  = 1'b0;
    s_d     = s_q;
    y_d     = y_q;
    vld_d   = vld_q;

    free_c = !vld_q || rdy;
    acc0_c = (state_q == OWN0) && req0 && free_c && !hand_q;
    acc1_c = (state_q == OWN1) && req1 && free_c && !hand_q;

    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_d = req1 ? OWN1 : IDLE;
        end else if (acc0_c && (cnt_q == CNT_LAST) && req1) begin
          state_d = OWN1;
          hand_d  = 1'b1;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = req0 ? OWN0 : IDLE;
        end else if (acc1_c && (cnt_q == CNT_LAST) && req0) begin
          state_d = OWN0;
          hand_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Burst count restarts on any ownership change and wraps at the limit.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (acc0_c || acc1_c) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    if ((state_d == OWN0) && (state_q != OWN0)) begin
      last_d = 1'b0;
    end else if ((state_d == OWN1) && (state_q != OWN1)) begin
      last_d = 1'b1;
    end

    if (acc0_c) begin
      y_d   = d0;
      s_d   = 1'b0;
      vld_d = 1'b1;
    end else if (acc1_c) begin
      y_d   = d1;
      s_d   = 1'b1;
      vld_d = 1'b1;
    end else if (vld_q && rdy) begin
      vld_d = 1'b0;
    end

    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign s    = s_q;
  assign y    = y_q;
  assign vld  = vld_q;

endmodule
